// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-road traffic light controller: decodes the lamp
// outputs into phases and flags conflicts, pair mismatches, bad order, bad dwell and bad blink timing.
`timescale 1ns/1ps

// state   | meaning
// --------+-------------------------------------------------
// P0      | main green, side red
// P1      | main yellow, side red (after P0)
// P2      | main red + main red-turn arrow, side red
// P3      | main yellow, side red (after P2)
// P4      | main red, side green
// P5      | main red, side yellow
// P6      | main red, side red + side red-turn arrow
// P7      | main red, side red + side yellow
// BLINK   | only yellows lit, or dark gap inside a blink run
// DARK    | all lamps off outside a blink run
// ILLEGAL | any other lamp pattern
module traffic_light_monitor #(
  parameter int TICK_DIV = 9_999_999,
  parameter int MAIN_T   = 450,
  parameter int SIDE_T   = 250,
  parameter int YEL_T    = 50,
  parameter int BLINK_T  = 10,
  parameter int TOL      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lamps,
  input  logic        fault_clr,
  output logic [3:0]  phase,
  output logic        phase_chg,
  output logic [9:0]  dwell_last,
  output logic        conflict_err,
  output logic        pair_err,
  output logic        pattern_err,
  output logic        seq_err,
  output logic        dwell_err,
  output logic        blink_err
);

  localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

  typedef enum logic [3:0] {
    P0      = 4'd0,
    P1      = 4'd1,
    P2      = 4'd2,
    P3      = 4'd3,
    P4      = 4'd4,
    P5      = 4'd5,
    P6      = 4'd6,
    P7      = 4'd7,
    BLINK   = 4'd8,
    DARK    = 4'd9,
    ILLEGAL = 4'd15
  } phase_e;

  phase_e phase_q, phase_d;

  logic [15:0]   lamp_q;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [9:0]    dwell_cnt, dwell_tot, exp_dw, dev_dw;
  logic [9:0]    blink_cnt, blink_tot, dev_bl;
  logic          first_q, my1_prev, armed;
  logic [7:0]    v1, v2;
  logic          pair_bad, conflict, yel_bad, legal, chg, toggle;
  logic          dwell_set, blink_set;
  logic          lit_mg, lit_my, lit_sg, lit_mrt, lit_srt;

  assign tick = (tick_cnt == TW'(TICK_DIV));

  // index-1 lamp of each pair drives decode; index-2 only for the pair check
  assign v1 = {lamp_q[15], lamp_q[13], lamp_q[11], lamp_q[9],
               lamp_q[7],  lamp_q[5],  lamp_q[3],  lamp_q[1]};
  assign v2 = {lamp_q[14], lamp_q[12], lamp_q[10], lamp_q[8],
               lamp_q[6],  lamp_q[4],  lamp_q[2],  lamp_q[0]};
  assign pair_bad = |(v1 ^ v2);

  // conflicts look at either lamp of a pair so a half-lit pair still counts
  assign lit_mg  = lamp_q[15] | lamp_q[14];
  assign lit_my  = lamp_q[11] | lamp_q[10];
  assign lit_sg  = lamp_q[9]  | lamp_q[8];
  assign lit_mrt = lamp_q[3]  | lamp_q[2];
  assign lit_srt = lamp_q[1]  | lamp_q[0];
  assign conflict = (lit_mg & (lit_sg | lit_srt)) | (lit_sg & (lit_mrt | lit_my));

  // next-phase decode
  always_comb begin
    phase_d = ILLEGAL;
    yel_bad = 1'b0;
    case (v1)
      8'b1000_1000: phase_d = P0;
      8'b0010_1000: begin
        case (phase_q)
          P0:      phase_d = P1;
          P1:      phase_d = P1;
          P2:      phase_d = P3;
          P3:      phase_d = P3;
          default: begin
            phase_d = P1;
            yel_bad = 1'b1;
          end
        endcase
      end
      8'b0100_1010: phase_d = P2;
      8'b0101_0000: phase_d = P4;
      8'b0100_0100: phase_d = P5;
      8'b0100_1001: phase_d = P6;
      8'b0100_1100: phase_d = P7;
      8'b0000_0000: phase_d = (phase_q == BLINK) ? BLINK : DARK;
      8'b0010_0000, 8'b0000_0100, 8'b0010_0100: phase_d = BLINK;
      default:      phase_d = ILLEGAL;
    endcase
  end

  assign chg = (phase_d != phase_q);

  always_comb begin
    legal = 1'b0;
    if (phase_d == ILLEGAL || phase_q == ILLEGAL || phase_d == BLINK)
      legal = 1'b1;
    else if (!phase_q[3])
      legal = ({1'b0, 3'(phase_q[2:0] + 3'd1)} == phase_d);
    else if (phase_q == BLINK || phase_q == DARK)
      legal = (phase_d == P0);
  end

  // the tick landing on the change cycle belongs to the phase being left
  assign dwell_tot = (tick && dwell_cnt != 10'h3FF) ? dwell_cnt + 10'd1 : dwell_cnt;

  always_comb begin
    exp_dw = 10'(YEL_T);
    case (phase_q)
      P0:         exp_dw = 10'(MAIN_T);
      P2, P4, P6: exp_dw = 10'(SIDE_T);
      default:    ;
    endcase
    dev_dw = (dwell_tot > exp_dw) ? dwell_tot - exp_dw : exp_dw - dwell_tot;
  end

  assign dwell_set = chg && !phase_q[3] && !first_q && (dev_dw > 10'(TOL));

  // a toggle only counts while the blink run continues, not on its exit
  assign toggle    = (phase_q == BLINK) && (phase_d == BLINK) && (lamp_q[11] != my1_prev);
  assign blink_tot = (tick && blink_cnt != 10'h3FF) ? blink_cnt + 10'd1 : blink_cnt;
  assign dev_bl    = (blink_tot > 10'(BLINK_T)) ? blink_tot - 10'(BLINK_T)
                                                 : 10'(BLINK_T) - blink_tot;
  assign blink_set = armed && (phase_q == BLINK) &&
                     ((toggle && dev_bl > 10'(TOL)) ||
                      (!toggle && {1'b0, blink_tot} >= 11'(2 * BLINK_T)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase_q <= DARK;
    else      phase_q <= phase_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lamp_q       <= '0;
      tick_cnt     <= '0;
      phase_chg    <= 1'b0;
      dwell_cnt    <= '0;
      dwell_last   <= '0;
      first_q      <= 1'b1;
      my1_prev     <= 1'b0;
      armed        <= 1'b0;
      blink_cnt    <= '0;
      conflict_err <= 1'b0;
      pair_err     <= 1'b0;
      pattern_err  <= 1'b0;
      seq_err      <= 1'b0;
      dwell_err    <= 1'b0;
      blink_err    <= 1'b0;
    end else begin
      lamp_q    <= lamps;
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
      phase_chg <= chg;
      my1_prev  <= lamp_q[11];

      if (chg) begin
        dwell_last <= dwell_tot;
        dwell_cnt  <= '0;
        first_q    <= phase_q[3];
      end else if (tick && dwell_cnt != 10'h3FF) begin
        dwell_cnt <= dwell_cnt + 10'd1;
      end

      if (phase_q != BLINK) begin
        armed     <= 1'b0;
        blink_cnt <= '0;
      end else if (toggle) begin
        armed     <= 1'b1;
        blink_cnt <= '0;
      end else if (tick && blink_cnt != 10'h3FF) begin
        blink_cnt <= blink_cnt + 10'd1;
      end

      // a fresh fault in the clearing cycle keeps its flag set
      conflict_err <= conflict                          | (conflict_err & ~fault_clr);
      pair_err     <= pair_bad                          | (pair_err     & ~fault_clr);
      pattern_err  <= (phase_d == ILLEGAL)              | (pattern_err  & ~fault_clr);
      seq_err      <= (chg && (!legal || yel_bad))      | (seq_err      & ~fault_clr);
      dwell_err    <= dwell_set                         | (dwell_err    & ~fault_clr);
      blink_err    <= blink_set                         | (blink_err    & ~fault_clr);
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: a table of lamp patterns with dwell times;
// expected phase reports are queued on drive and checked on each phase_chg.
`timescale 1ns/1ps

module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] lamps = '0;
  logic        fault_clr = 1'b0;
  logic [3:0]  phase;
  logic        phase_chg;
  logic [9:0]  dwell_last;
  logic        conflict_err, pair_err, pattern_err, seq_err, dwell_err, blink_err;
  logic [5:0]  flags;

  traffic_light_monitor #(.TICK_DIV(9)) dut (
    .clk(clk), .rst(rst), .lamps(lamps), .fault_clr(fault_clr),
    .phase(phase), .phase_chg(phase_chg), .dwell_last(dwell_last),
    .conflict_err(conflict_err), .pair_err(pair_err), .pattern_err(pattern_err),
    .seq_err(seq_err), .dwell_err(dwell_err), .blink_err(blink_err)
  );

  always #5 clk = ~clk;

  assign flags = {conflict_err, pair_err, pattern_err, seq_err, dwell_err, blink_err};

  localparam logic [5:0] F_CON = 6'b100000, F_PAIR = 6'b010000, F_PAT = 6'b001000,
                         F_SEQ = 6'b000100, F_DW   = 6'b000010, F_BLK = 6'b000001;
  // {MG, MR, MY, SG, SR, SY, MRT, SRT}
  localparam logic [7:0] L_P0 = 8'b1000_1000, L_Y  = 8'b0010_1000, L_P2 = 8'b0100_1010,
                         L_P4 = 8'b0101_0000, L_P5 = 8'b0100_0100, L_P6 = 8'b0100_1001,
                         L_P7 = 8'b0100_1100, L_BL = 8'b0010_0100, L_OFF = 8'b0000_0000,
                         L_ILL = 8'b1100_1000, L_CON = 8'b1001_0000;

  typedef struct {
    logic [15:0] lamps;
    int          hold;
    bit          clr;
    bit          chg;
    bit          mid;
    logic [3:0]  ph;
    logic [9:0]  dw;
    bit          dwchk;
    logic [5:0]  fl;
  } vec_t;

  vec_t tbl[27];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [15:0] mk(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = v[i];
    end
    return r;
  endfunction

  function automatic vec_t rec(input logic [7:0] v, input int hold, input bit clr,
                               input bit chg, input bit mid, input int ph, input int dw,
                               input bit dwchk, input logic [5:0] fl);
    vec_t r;
    r.lamps = mk(v);
    r.hold  = hold;
    r.clr   = clr;
    r.chg   = chg;
    r.mid   = mid;
    r.ph    = 4'(ph);
    r.dw    = 10'(dw);
    r.dwchk = dwchk;
    r.fl    = fl;
    return r;
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // scoreboard consumer: one queued expectation per phase change
  always @(negedge clk) begin
    if (rst && phase_chg) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected phase_chg: phase %0d, no expectation queued", phase);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("phase", int'(phase), int'(e.ph));
        if (e.dwchk) chk("dwell_last", int'(dwell_last), int'(e.dw));
        chk("flags", int'(flags), int'(e.fl));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete, %0d expectations pending", exp_q.size());
    $fatal(1);
  end

  initial begin
    //            lamps  hold clr chg mid ph  dw  dwchk flags
    tbl[0]  = rec(L_P0,  450, 0, 1, 0, 0,   0, 0, 6'd0);
    tbl[1]  = rec(L_Y,    50, 0, 1, 0, 1, 450, 1, 6'd0);
    tbl[2]  = rec(L_P2,  250, 0, 1, 0, 2,  50, 1, 6'd0);
    tbl[3]  = rec(L_Y,    50, 0, 1, 0, 3, 250, 1, 6'd0);
    tbl[4]  = rec(L_P4,  250, 0, 1, 0, 4,  50, 1, 6'd0);
    tbl[5]  = rec(L_P5,   50, 0, 1, 0, 5, 250, 1, 6'd0);
    tbl[6]  = rec(L_P6,  250, 0, 1, 0, 6,  50, 1, 6'd0);
    tbl[7]  = rec(L_P7,   50, 0, 1, 0, 7, 250, 1, 6'd0);
    tbl[8]  = rec(L_P0,  460, 0, 1, 0, 0,  50, 1, 6'd0);
    tbl[9]  = rec(L_Y,    10, 0, 1, 0, 1, 460, 1, F_DW);
    tbl[10] = rec(L_ILL,   5, 0, 1, 0, 15, 10, 1, F_DW | F_PAT);
    tbl[11] = rec(L_P7,   50, 1, 1, 0, 7,   5, 1, 6'd0);
    tbl[12] = rec(L_P0,  451, 0, 1, 0, 0,  50, 1, 6'd0);
    tbl[13] = rec(L_Y,    50, 0, 1, 0, 1, 451, 1, 6'd0);
    tbl[14] = rec(L_BL,   10, 0, 1, 0, 8,  50, 1, 6'd0);
    tbl[15] = rec(L_OFF,  10, 0, 0, 0, 8,   0, 0, 6'd0);
    tbl[16] = rec(L_BL,   10, 0, 0, 0, 8,   0, 0, 6'd0);
    tbl[17] = rec(L_OFF,  10, 0, 0, 1, 8,   0, 0, 6'd0);
    tbl[18] = rec(L_BL,   13, 0, 0, 0, 8,   0, 0, 6'd0);
    tbl[19] = rec(L_OFF,  10, 0, 0, 1, 8,   0, 0, F_BLK);
    tbl[20] = rec(L_P0,   10, 0, 1, 0, 0,  63, 1, F_BLK);
    tbl[21] = rec(L_P4,   10, 1, 1, 0, 4,  10, 1, F_SEQ);
    tbl[22] = rec(L_CON,   5, 0, 1, 0, 15, 10, 1, F_CON | F_PAT | F_SEQ | F_DW);
    tbl[23] = rec(L_OFF,  10, 1, 1, 0, 9,   5, 1, 6'd0);
    tbl[24] = rec(L_P0,   10, 0, 1, 0, 0,  10, 1, F_PAIR);
    tbl[25] = rec(L_Y,    50, 1, 1, 0, 1,  10, 1, 6'd0);
    tbl[26] = rec(L_P2,   20, 0, 1, 0, 2,  50, 1, 6'd0);
    tbl[24].lamps[14] = 1'b0;  // MG2 dark while MG1 lit

    #23;
    chk("reset phase", int'(phase), 9);
    chk("reset phase_chg", int'(phase_chg), 0);
    chk("reset dwell_last", int'(dwell_last), 0);
    chk("reset flags", int'(flags), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (7) @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) begin
      lamps     = tbl[i].lamps;
      fault_clr = tbl[i].clr;
      if (tbl[i].chg) exp_q.push_back(tbl[i]);
      for (int c = 0; c < tbl[i].hold * 10; c++) begin
        @(posedge clk);
        #1;
        if (c == 1) fault_clr = 1'b0;
      end
      if (tbl[i].mid) chk($sformatf("flags mid-blink row %0d", i), int'(flags), int'(tbl[i].fl));
    end

    chk("pending expectations", exp_q.size(), 0);

    // reset in the middle of P2 must clear everything at once
    chk("pre-reset phase", int'(phase), 2);
    chk("pre-reset dwell_last", int'(dwell_last), 50);
    #2 rst = 1'b0;
    #1;
    chk("async reset phase", int'(phase), 9);
    chk("async reset phase_chg", int'(phase_chg), 0);
    chk("async reset dwell_last", int'(dwell_last), 0);
    chk("async reset flags", int'(flags), 0);
    lamps = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post-reset phase", int'(phase), 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
